reg_piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: the sending end of the serial shift-register link.
//  - Accepts an N-bit word on a valid/ready handshake and emits it one bit per enabled clock.
//  - Bit order (MSB-first or LSB-first) is selected per word.
//  - Drives the serial D input of a downstream reg_siso chain that shares the same clk/enable.

---
 rtl/reg_piso_tx.sv | 100 ++++++++++
 tb/tb_reg_piso_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_piso_tx.sv
// reg_piso_tx: parallel-in/serial-out transmitter feeding a serial shift-register link.
// A word is taken on a valid/ready handshake and shifted out one bit per enabled clock,
// MSB-first or LSB-first as selected at load time.
// Optional feature: define PARITY_EN to append an even-parity bit after the data bits.
module reg_piso_tx #(
  parameter int   N        = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         dir,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] D,
  output logic         Q,
  output logic         q_valid,
  output logic         busy,
  output logic         done
);

`ifdef PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [L-1:0]    shreg_q;
  logic [CW-1:0]   cnt_q;
  logic            dir_q;
  logic [L-1:0]    load_word_d;

  // Word as placed in the shift register; the parity bit sits at the far end
  // from the output so it leaves after the data bits in either bit order.
  always_comb begin
`ifdef PARITY_EN
    load_word_d = dir ? {D, ^D} : {^D, D};
`else
    load_word_d = D;
`endif
  end

  // Transmit FSM: load in IDLE, shift on enable in SHIFT, single DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            shreg_q <= load_word_d;
            dir_q   <= dir;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (enable) begin
            // Shift toward the output end with zero fill.
            shreg_q <= dir_q ? {shreg_q[L-2:0], 1'b0} : {1'b0, shreg_q[L-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CW'(L - 1)) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    load_ready = (state_q == S_IDLE);
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    q_valid    = (state_q == S_SHIFT) && enable;
    Q          = IDLE_LVL;
    if (state_q == S_SHIFT) begin
      Q = dir_q ? shreg_q[L-1] : shreg_q[0];
    end
  end

endmodule

// File: tb/tb_reg_piso_tx.sv
// Testbench for reg_piso_tx: expected serial bits are queued at load time and
// popped whenever the DUT flags a valid bit. Define PARITY_EN to test the parity build.
module tb_reg_piso_tx;

  localparam int N = 4;
`ifdef PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam logic IDLE_LVL = 1'b0;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         dir;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] D;
  logic         Q;
  logic         q_valid;
  logic         busy;
  logic         done;

  int checks;
  int failures;
  bit exp_q[$];
  logic [N-1:0] siso_q;

  reg_piso_tx #(.N(N), .IDLE_LVL(IDLE_LVL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .D          (D),
    .Q          (Q),
    .q_valid    (q_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-stage serial chain sharing clk and enable.
  always @(posedge clk) begin
    if (enable) siso_q <= {siso_q[N-2:0], Q};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected serial stream for one word.
  task automatic push_word(input logic [N-1:0] d, input logic dr);
    for (int i = 0; i < N; i++) exp_q.push_back(dr ? d[N-1-i] : d[i]);
`ifdef PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of cycle 1.
  task automatic do_load(input logic [N-1:0] d, input logic dr);
    D = d;
    dir = dr;
    load_valid = 1'b1;
    push_word(d, dr);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b1; dir = 1'b0; load_valid = 1'b0; D = '0;
    @(negedge clk);
    checks++; if (Q !== IDLE_LVL) begin failures++; $display("FAIL reset_Q: got %0b expected %0b", Q, IDLE_LVL); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %0b expected 1", load_ready); end
    checks++; if ({q_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %03b expected 000", {q_valid, busy, done}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_release: got ready=%0b busy=%0b expected 1/0", load_ready, busy); end
    @(posedge clk); #1;
  endtask

  // Full word with enable high: bits on cycles 1..L, done on L+1, ready on L+2.
  task automatic test_word(input string name, input logic [N-1:0] d, input logic dr);
    bit b;
    do_load(d, dr);
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k <= L) begin
        checks++; if (q_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL %s_valid c%0d: got q_valid=%0b busy=%0b expected 1/1", name, k, q_valid, busy); end
        if (exp_q.size() == 0) begin failures++; $display("FAIL %s_underflow c%0d", name, k); end
        else begin
          b = exp_q.pop_front();
          checks++; if (Q !== b) begin failures++; $display("FAIL %s_Q c%0d: got %0b expected %0b", name, k, Q, b); end
        end
      end else if (k == L + 1) begin
        checks++; if (done !== 1'b1 || Q !== IDLE_LVL || load_ready !== 1'b0) begin failures++; $display("FAIL %s_done c%0d: got done=%0b Q=%0b ready=%0b expected 1/%0b/0", name, k, done, Q, load_ready, IDLE_LVL); end
      end else begin
        checks++; if (load_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL %s_idle c%0d: got ready=%0b done=%0b expected 1/0", name, k, load_ready, done); end
      end
      if (k == N + 1 && dr) begin
        checks++; if (siso_q !== d) begin failures++; $display("FAIL %s_siso: got %04b expected %04b", name, siso_q, d); end
      end
      @(posedge clk); #1;
    end
    $display("word %s D=%04b dir=%0b done", name, d, dr);
  endtask

  task automatic test_enable_hold;
    bit b;
    int sent;
    int cyc;
    sent = 0; cyc = 1;
    do_load(4'b1100, 1'b1);
    while (sent < L && cyc < 30) begin
      enable = !(cyc == 2 || cyc == 3);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy c%0d: got %0b expected 1", cyc, busy); end
      if (enable) begin
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL hold_valid c%0d: got %0b expected 1", cyc, q_valid); end
        b = exp_q.pop_front();
        checks++; if (Q !== b) begin failures++; $display("FAIL hold_Q c%0d: got %0b expected %0b", cyc, Q, b); end
        sent++;
      end else begin
        checks++; if (q_valid !== 1'b0 || Q !== exp_q[0]) begin failures++; $display("FAIL hold_stall c%0d: got q_valid=%0b Q=%0b expected 0/%0b", cyc, q_valid, Q, exp_q[0]); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL hold_done c%0d: got %0b expected 1", cyc, done); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("word enable_hold D=1100 dir=1 done");
  endtask

  task automatic test_ignore_load;
    bit b;
    do_load(4'b1011, 1'b1);
    load_valid = 1'b1;
    for (int k = 1; k <= L + 2; k++) begin
      if (k >= 2 && k <= L) begin
        D = 4'b0000;
        dir = ~dir;
      end
      if (k == L + 1) load_valid = 1'b0;
      @(negedge clk);
      if (k <= L) begin
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL ignore_ready c%0d: got %0b expected 0", k, load_ready); end
        b = exp_q.pop_front();
        checks++; if (Q !== b || q_valid !== 1'b1) begin failures++; $display("FAIL ignore_Q c%0d: got Q=%0b q_valid=%0b expected %0b/1", k, Q, q_valid, b); end
      end else if (k == L + 1) begin
        checks++; if (done !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("FAIL ignore_done: got done=%0b ready=%0b expected 1/0", done, load_ready); end
      end else begin
        checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ignore_idle: got ready=%0b busy=%0b expected 1/0", load_ready, busy); end
      end
      @(posedge clk); #1;
    end
    $display("word ignore_load D=1011 dir=1 done");
  endtask

  task automatic test_abort;
    bit b;
    do_load(4'b1011, 1'b1);
    @(negedge clk);
    b = exp_q.pop_front();
    checks++; if (Q !== b || busy !== 1'b1) begin failures++; $display("FAIL abort_first: got Q=%0b busy=%0b expected %0b/1", Q, busy, b); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (Q !== IDLE_LVL || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_reset: got Q=%0b busy=%0b done=%0b expected %0b/0/0", Q, busy, done, IDLE_LVL); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (load_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_after c%0d: got ready=%0b done=%0b expected 1/0", k, load_ready, done); end
      @(posedge clk); #1;
    end
    $display("word abort D=1011 aborted");
    test_word("after_abort", 4'b0110, 1'b0);
  endtask

  task automatic test_back_to_back;
    bit b;
    int sent;
    sent = 0;
    do_load(4'b1001, 1'b1);
    for (int k = 1; k <= 2 * L + 3; k++) begin
      if (k == L) begin
        D = 4'b0111;
        dir = 1'b0;
        load_valid = 1'b1;
        push_word(4'b0111, 1'b0);
      end
      if (k == L + 3) load_valid = 1'b0;
      @(negedge clk);
      if (k <= L || (k >= L + 3 && k <= 2 * L + 2)) begin
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid c%0d: got %0b expected 1", k, q_valid); end
        b = exp_q.pop_front();
        checks++; if (Q !== b) begin failures++; $display("FAIL b2b_Q c%0d: got %0b expected %0b", k, Q, b); end
        sent++;
      end else if (k == L + 1 || k == 2 * L + 3) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done c%0d: got %0b expected 1", k, done); end
      end else begin
        checks++; if (load_ready !== 1'b1 || q_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap c%0d: got ready=%0b q_valid=%0b expected 1/0", k, load_ready, q_valid); end
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    $display("words back_to_back 1001/0111 done, %0d bits", sent);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    siso_q = '0;
    test_reset();
    test_word("msb", 4'b1011, 1'b1);
    test_word("lsb", 4'b1011, 1'b0);
    test_enable_hold();
    test_ignore_load();
    test_abort();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL leftover_bits: got %0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
